// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: mode encodings, default sizes and the result entry layout.
package cordic_pkg;

  localparam int CORDIC_ITERATIONS    = 17;
  // The final iteration index is fed by this many registered stages.
  localparam int PIPE_LATENCY_DEFAULT = CORDIC_ITERATIONS - 1;
  localparam int DATA_W_DEFAULT       = 32;
  localparam int FIFO_DEPTH_DEFAULT   = 8;

  typedef enum logic [1:0] {
    LINEAR     = 2'b00,
    CIRCULAR   = 2'b10,
    HYPERBOLIC = 2'b11
  } cordic_mode_e;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] x;
    logic [DATA_W_DEFAULT-1:0] y;
    logic [DATA_W_DEFAULT-1:0] angle;
    cordic_mode_e              mode;
  } cordic_result_t;

  // Pointer width carrying one extra wrap bit above the slot index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// First-word fall-through result FIFO: the head slot is presented combinationally at rd_ptr.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = 3 * DATA_W_DEFAULT + 2,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MSB = PTR_W'(1) << (PTR_W - 1);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [WIDTH-1:0] slot_data [DEPTH];

  generate
    if (DEPTH > 1) begin : g_idx
      assign wr_idx = wr_ptr_reg[IDX_W-1:0];
      assign rd_idx = rd_ptr_reg[IDX_W-1:0];
    end else begin : g_idx_one
      assign wr_idx = '0;
      assign rd_idx = '0;
    end
  endgenerate

  // Same slot index with opposite wrap bits means every slot is occupied.
  assign full    = (wr_ptr_reg == (rd_ptr_reg ^ PTR_MSB));
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = slot_data[rd_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_reg <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        data_reg <= wr_data;
      end
    end

    assign slot_data[gi] = data_reg;
  end

endmodule

// File: rtl/cordic_result_collector.sv
// CORDIC result collector: valid/mode token pipe beside the datapath, FWFT result FIFO, issue credits.
// Define CORDIC_COLLECTOR_OVF_CHECK_EN to build the sticky err_overflow checker.
module cordic_result_collector
  import cordic_pkg::*;
#(
  parameter int PIPE_LATENCY = PIPE_LATENCY_DEFAULT,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [1:0]        issue_mode,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] cordic_x,
  input  logic [DATA_W-1:0] cordic_y,
  input  logic [DATA_W-1:0] cordic_angle,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_x,
  output logic [DATA_W-1:0] res_y,
  output logic [DATA_W-1:0] res_angle,
  output logic [1:0]        res_mode,
  output logic              err_overflow
);

  localparam int ENTRY_W = 3 * DATA_W + 2;
  localparam int CRED_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = ptr_width(FIFO_DEPTH);

  logic [PIPE_LATENCY-1:0]      tok_valid;
  logic [PIPE_LATENCY-1:0][1:0] tok_mode;
  logic                         tail_valid;
  logic [1:0]                   tail_mode;
  logic                         issue_accept;
  logic                         pop;
  logic                         capture;
  logic [CRED_W-1:0]            credits_reg;
  logic [CRED_W-1:0]            credits_next;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [PTR_W-1:0]             fifo_count;
  logic [ENTRY_W-1:0]           wr_entry;
  logic [ENTRY_W-1:0]           head_entry;
  logic                         unused_empty;

  assign issue_ready  = (credits_reg != '0);
  assign issue_accept = issue_valid & issue_ready;
  assign res_valid    = (fifo_count != '0);
  assign pop          = res_valid & res_ready;
  assign unused_empty = fifo_empty;

  // Each stage mirrors one CORDIC register stage; a token marks a live sample there.
  for (genvar gi = 0; gi < PIPE_LATENCY; gi++) begin : g_stage
    logic       valid_reg;
    logic [1:0] mode_reg;
    logic       valid_in;
    logic [1:0] mode_in;

    if (gi == 0) begin : g_head
      assign valid_in = issue_accept;
      assign mode_in  = issue_mode;
    end else begin : g_body
      assign valid_in = tok_valid[gi-1];
      assign mode_in  = tok_mode[gi-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        valid_reg <= 1'b0;
        mode_reg  <= 2'b00;
      end else begin
        valid_reg <= valid_in;
        mode_reg  <= mode_in;
      end
    end

    assign tok_valid[gi] = valid_reg;
    assign tok_mode[gi]  = mode_reg;
  end

  assign tail_valid = tok_valid[PIPE_LATENCY-1];
  assign tail_mode  = tok_mode[PIPE_LATENCY-1];
  assign wr_entry   = {cordic_x, cordic_y, cordic_angle, tail_mode};
  assign {res_x, res_y, res_angle, res_mode} = head_entry;

  always_comb begin
    credits_next = credits_reg;
    if (issue_accept && !pop) begin
      credits_next = credits_reg - CRED_W'(1);
    end else if (!issue_accept && pop) begin
      credits_next = credits_reg + CRED_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits_reg <= CRED_W'(FIFO_DEPTH);
    end else begin
      credits_reg <= credits_next;
    end
  end

`ifdef CORDIC_COLLECTOR_OVF_CHECK_EN
  logic err_overflow_reg;
  logic capture_ovf;
  logic credit_underflow;
  logic credit_overflow;

  // A same-cycle pop frees the head slot, so only an unmatched capture into a full FIFO overflows.
  assign capture_ovf      = tail_valid & fifo_full & ~pop;
  assign credit_underflow = issue_accept & ~pop & (credits_reg == '0);
  assign credit_overflow  = pop & ~issue_accept & (credits_reg == CRED_W'(FIFO_DEPTH));
  assign capture          = tail_valid & ~capture_ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_overflow_reg <= 1'b0;
    end else if (capture_ovf || credit_underflow || credit_overflow) begin
      err_overflow_reg <= 1'b1;
    end
  end

  assign err_overflow = err_overflow_reg;
`else
  logic unused_full;

  assign capture      = tail_valid;
  assign err_overflow = 1'b0;
  assign unused_full  = fifo_full;
`endif

  cordic_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (capture),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_cordic_result_collector.sv
// Scoreboard bench for cordic_result_collector: emulates CORDIC output timing and checks results in order.
module tb_cordic_result_collector;
  import cordic_pkg::*;

  localparam int PIPE  = 16;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          issue_valid = 1'b0;
  logic [1:0]    issue_mode = 2'b00;
  logic          issue_ready;
  logic [DW-1:0] cordic_x = '0;
  logic [DW-1:0] cordic_y = '0;
  logic [DW-1:0] cordic_angle = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_x;
  logic [DW-1:0] res_y;
  logic [DW-1:0] res_angle;
  logic [1:0]    res_mode;
  logic          err_overflow;

  cordic_result_collector #(
    .PIPE_LATENCY (PIPE),
    .FIFO_DEPTH   (DEPTH),
    .DATA_W       (DW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_mode   (issue_mode),
    .issue_ready  (issue_ready),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_angle (cordic_angle),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_x        (res_x),
    .res_y        (res_y),
    .res_angle    (res_angle),
    .res_mode     (res_mode),
    .err_overflow (err_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] a;
  } emu_t;

  typedef struct {
    int unsigned    due;
    cordic_result_t r;
  } sb_t;

  emu_t        emu_q[$];
  sb_t         sb_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          err_exp = 1'b0;
  logic [1:0]  mode_tab [3] = '{2'b00, 2'b10, 2'b11};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Plays the CORDIC tail: an issued sample's result appears exactly PIPE cycles after issue.
  task automatic drive_cordic();
    emu_t e;
    while (emu_q.size() > 0 && emu_q[0].due < cyc) void'(emu_q.pop_front());
    if (emu_q.size() > 0 && emu_q[0].due == cyc) begin
      e = emu_q.pop_front();
      cordic_x     = e.x;
      cordic_y     = e.y;
      cordic_angle = e.a;
    end else begin
      cordic_x     = $urandom;
      cordic_y     = $urandom;
      cordic_angle = $urandom;
    end
  endtask

  task automatic step_clock();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_cycle(input bit iv, input logic [1:0] im, input logic [DW-1:0] x,
                           input logic [DW-1:0] y, input logic [DW-1:0] a, input bit rr,
                           output bit acc);
    sb_t e;
    bit  exp_valid;
    drive_cordic();
    issue_valid = iv;
    issue_mode  = im;
    res_ready   = rr;
    exp_valid   = (sb_q.size() > 0) && (sb_q[0].due < cyc);
    check_val("issue_ready", 64'(issue_ready), 64'(sb_q.size() < DEPTH));
    check_val("res_valid", 64'(res_valid), 64'(exp_valid));
    check_val("err_overflow", 64'(err_overflow), 64'(err_exp));
    acc = iv && issue_ready;
    if (res_valid && rr && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("res_x", 64'(res_x), 64'(e.r.x));
      check_val("res_y", 64'(res_y), 64'(e.r.y));
      check_val("res_angle", 64'(res_angle), 64'(e.r.angle));
      check_val("res_mode", 64'(res_mode), 64'(e.r.mode));
      $display("cycle %0d pop x=%h y=%h angle=%h mode=%b", cyc, res_x, res_y, res_angle, res_mode);
    end
    if (acc) begin
      emu_q.push_back('{cyc + PIPE, x, y, a});
      e.due     = cyc + PIPE;
      e.r.x     = x;
      e.r.y     = y;
      e.r.angle = a;
      e.r.mode  = cordic_mode_e'(im);
      sb_q.push_back(e);
    end
    step_clock();
  endtask

  task automatic apply_reset();
    reset_n     = 1'b0;
    issue_valid = 1'b0;
    res_ready   = 1'b0;
    #1;
    check_val("rst_res_valid", 64'(res_valid), 64'd0);
    check_val("rst_res_x", 64'(res_x), 64'd0);
    check_val("rst_res_y", 64'(res_y), 64'd0);
    check_val("rst_res_angle", 64'(res_angle), 64'd0);
    check_val("rst_res_mode", 64'(res_mode), 64'd0);
    check_val("rst_issue_ready", 64'(issue_ready), 64'd1);
    check_val("rst_err_overflow", 64'(err_overflow), 64'd0);
    sb_q.delete();
    err_exp = 1'b0;
    repeat (3) begin
      drive_cordic();
      step_clock();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int n;
    int k;

    #2;
    apply_reset();

    // Single CIRCULAR sample with the documented values.
    run_cycle(1'b1, 2'b10, 32'h0000_1234, 32'h0000_0000, 32'h1000_0000, 1'b1, acc);
    check_val("single_accept", 64'(acc), 64'd1);
    repeat (20) run_cycle(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
    check_val("single_drained", 64'(sb_q.size()), 64'd0);

    // Backpressure: issue every cycle with the consumer stalled.
    n = 0;
    for (int i = 0; i < 30; i++) begin
      run_cycle(1'b1, mode_tab[i % 3], DW'(100 + n), $urandom, $urandom, 1'b0, acc);
      if (acc) n++;
    end
    check_val("bp_accepted", 64'(n), 64'd8);
    check_val("bp_issue_ready", 64'(issue_ready), 64'd0);
    check_val("bp_res_valid", 64'(res_valid), 64'd1);

`ifdef CORDIC_COLLECTOR_OVF_CHECK_EN
    force dut.tail_valid = 1'b1;
    run_cycle(1'b0, 2'b00, '0, '0, '0, 1'b0, acc);
    release dut.tail_valid;
    err_exp = 1'b1;
    repeat (2) run_cycle(1'b0, 2'b00, '0, '0, '0, 1'b0, acc);
`endif

    // Drain three, then exactly three credits are available again.
    repeat (3) run_cycle(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
    check_val("drain_left", 64'(sb_q.size()), 64'd5);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, mode_tab[i % 3], DW'(200 + i), $urandom, $urandom, 1'b0, acc);
      if (acc) n++;
    end
    check_val("refill_accepted", 64'(n), 64'd3);

    // Wrap-around stream of 40 tagged samples with a toggling consumer.
    k = 0;
    for (int c = 0; c < 3000 && (k < 40 || sb_q.size() > 0); c++) begin
      run_cycle(k < 40, mode_tab[k % 3], DW'(k), $urandom, $urandom, c[0], acc);
      if (acc) k++;
    end
    check_val("stream_done", 64'((k == 40) && (sb_q.size() == 0)), 64'd1);

    // Reset with three buffered and five in flight.
    for (int i = 0; i < 19; i++) begin
      run_cycle((i < 3) || (i >= 10 && i < 15), mode_tab[i % 3], DW'(300 + i),
                $urandom, $urandom, 1'b0, acc);
    end
    check_val("pre_reset_outstanding", 64'(sb_q.size()), 64'd8);
    check_val("pre_reset_valid", 64'(res_valid), 64'd1);
    apply_reset();
    repeat (30) run_cycle(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, mode_tab[i % 3], DW'(400 + i), $urandom, $urandom, 1'b0, acc);
      if (acc) n++;
    end
    check_val("post_reset_credits", 64'(n), 64'd8);
    for (int c = 0; c < 200 && sb_q.size() > 0; c++) begin
      run_cycle(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
    end
    check_val("final_drain", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
